// File: rtl/tone_pkg.sv
// Shared tone constants and detector state encoding; the buzzer generator
// imports the same defaults so both ends of the line agree on frequency.
package tone_pkg;

  localparam int DEF_CNT_W       = 26;
  localparam int DEF_HALF_PERIOD = 12001;
  localparam int DEF_TOL         = 600;
  localparam int DEF_LOCK_COUNT  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    LOCKED   = 2'd3
  } tone_state_t;

  // Lower edge of the acceptance window, clamped at zero for wide tolerances.
  function automatic int win_lo(input int half_period, input int tol);
    return (tol > half_period) ? 0 : half_period - tol;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus edge register: edge_det pulses for one cycle on
// either polarity change, two CLK cycles after async_in is first sampled.
module sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic edge_det
);

  logic s1, s2, s3;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 ^ s3;

endmodule

// File: rtl/tone_detector.sv
// Square-wave frequency lock detector; DETECTED/TONE_LOST are registered, 3 CLK after TONE_IN edge, no backpressure.
// Optional TONE_DETECTOR_PERIOD_OUT_EN exposes last_interval / interval_valid.
module tone_detector
  import tone_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             TONE_IN,
  output logic             DETECTED,
  output logic             TONE_LOST
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
  ,
  output logic [CNT_W-1:0] last_interval,
  output logic             interval_valid
`endif
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(win_lo(HALF_PERIOD, TOL));
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GC_W-1:0]  LOCK_N  = GC_W'(LOCK_COUNT);

  tone_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d, good_inc;
  logic             edge_det, good, timeout, upd;
  logic             det_d, lost_d;

  sync_edge u_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_in (TONE_IN),
    .edge_det (edge_det)
  );

  // On an edge cycle cnt_q is the interval since the previous edge.
  assign good     = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  assign timeout  = !edge_det && (cnt_q > WIN_HI);
  assign good_inc = good_cnt_q + GC_W'(1);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    det_d      = DETECTED;
    lost_d     = 1'b0;
    upd        = 1'b0;
    if (edge_det)
      cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;

    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      good_cnt_d = '0;
      det_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARMED;
        end
        ARMED: begin
          if (edge_det) begin
            state_d    = COUNTING;
            good_cnt_d = '0;
          end
        end
        COUNTING: begin
          if (edge_det) begin
            upd = 1'b1;
            if (good) begin
              good_cnt_d = good_inc;
              if (good_inc == LOCK_N) begin
                state_d = LOCKED;
                det_d   = 1'b1;
              end
            end else begin
              good_cnt_d = '0;
            end
          end else if (timeout) begin
            state_d    = ARMED;
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (edge_det) upd = 1'b1;
          // A bad edge is consumed here; ARMED waits for a fresh reference.
          if ((edge_det && !good) || timeout) begin
            state_d    = ARMED;
            good_cnt_d = '0;
            det_d      = 1'b0;
            lost_d     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_cnt_q <= '0;
      DETECTED   <= 1'b0;
      TONE_LOST  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_cnt_q <= good_cnt_d;
      DETECTED   <= det_d;
      TONE_LOST  <= lost_d;
    end
  end

`ifdef TONE_DETECTOR_PERIOD_OUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_interval  <= '0;
      interval_valid <= 1'b0;
    end else begin
      interval_valid <= upd;
      if (upd) last_interval <= cnt_q;
    end
  end
`else
  logic unused_upd;
  assign unused_upd = upd;
`endif

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: table-driven interval patterns, hand sequences for
// reset/disable, and random interval streams against an event-level model.
module tb_tone_detector;

  localparam int CNT_W = 26;
  localparam int HP    = 100;
  localparam int TOL   = 5;
  localparam int LC    = 4;
  localparam int LO    = HP - TOL;
  localparam int HI    = HP + TOL;
  localparam int MAXL  = 4000;

  logic CLK = 1'b0;
  logic RST, enable, TONE_IN;
  logic DETECTED, TONE_LOST;
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
  logic [CNT_W-1:0] last_interval;
  logic             interval_valid;
`endif

  tone_detector #(.CNT_W(CNT_W), .HALF_PERIOD(HP), .TOL(TOL), .LOCK_COUNT(LC)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .TONE_IN   (TONE_IN),
    .DETECTED  (DETECTED),
    .TONE_LOST (TONE_LOST)
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
    ,
    .last_interval  (last_interval),
    .interval_valid (interval_valid)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  int tog_at  [MAXL];
  int en_val  [MAXL];
  int det_got [MAXL];
  int lost_got[MAXL];
  int li_got  [MAXL];
  int ivv_got [MAXL];
  int det_exp [MAXL];
  int lost_exp[MAXL];
  int li_exp  [MAXL];
  int ivv_exp [MAXL];
  int ivq[$];

  typedef struct packed {
    int              n;
    logic [7:0][15:0] iv;
    logic            det_end;
    logic            lost_end;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s_%0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input bit det, input bit lost,
                              input int a0, input int a1, input int a2, input int a3,
                              input int a4 = 0, input int a5 = 0, input int a6 = 0, input int a7 = 0);
    vec_t v;
    v.n = n; v.det_end = det; v.lost_end = lost;
    v.iv[0] = 16'(a0); v.iv[1] = 16'(a1); v.iv[2] = 16'(a2); v.iv[3] = 16'(a3);
    v.iv[4] = 16'(a4); v.iv[5] = 16'(a5); v.iv[6] = 16'(a6); v.iv[7] = 16'(a7);
    return v;
  endfunction

  task automatic do_reset();
    RST = 1'b1; enable = 1'b0; TONE_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0; enable = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  // Toggle times from the interval queue; returns the last toggle cycle.
  function automatic int build_sched();
    int t = 5;
    for (int c = 0; c < MAXL; c++) begin tog_at[c] = 0; en_val[c] = 1; end
    tog_at[t] = 1;
    foreach (ivq[k]) begin t += ivq[k]; tog_at[t] = 1; end
    return t;
  endfunction

  function automatic void set_det(input int t, input int v, input int L);
    for (int c = t; c < L; c++) det_exp[c] = v;
  endfunction

  function automatic void pulse_lost(input int t, input int L);
    if (t < L) lost_exp[t] = 1;
  endfunction

  function automatic void set_li(input int t, input int v, input int L);
    if (t < L) ivv_exp[t] = 1;
    for (int c = t; c < L; c++) li_exp[c] = v;
  endfunction

  // Event-level reference: walk the list of edge arrival times and apply the
  // window / lock-count / timeout rules interval by interval.
  function automatic void model(input int L);
    int e[$];
    int mode, rf, good, ei, iv;
    for (int c = 0; c < L; c++) begin
      det_exp[c] = 0; lost_exp[c] = 0; li_exp[c] = 0; ivv_exp[c] = 0;
      if (tog_at[c] != 0) e.push_back(c + 3);
    end
    mode = 0; rf = 0; good = 0;
    for (int i = 0; i <= e.size(); i++) begin
      ei = (i < e.size()) ? e[i] : (1 << 30);
      if (mode != 0 && ei - rf > HI + 1) begin
        if (mode == 2) begin set_det(rf + HI + 1, 0, L); pulse_lost(rf + HI + 1, L); end
        mode = 0;
      end
      if (i == e.size()) break;
      if (mode == 0) begin
        rf = ei; mode = 1; good = 0;
      end else begin
        iv = ei - rf; rf = ei;
        set_li(ei, iv, L);
        if (iv >= LO && iv <= HI) begin
          if (mode == 1) begin
            good++;
            if (good == LC) begin mode = 2; set_det(ei, 1, L); end
          end
        end else if (mode == 1) begin
          good = 0;
        end else begin
          mode = 0; set_det(ei, 0, L); pulse_lost(ei, L);
        end
      end
    end
  endfunction

  task automatic drive(input int L);
    for (int c = 0; c < L; c++) begin
      @(posedge CLK);
      #1;
      det_got[c]  = int'(DETECTED);
      lost_got[c] = int'(TONE_LOST);
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
      li_got[c]  = int'(last_interval);
      ivv_got[c] = int'(interval_valid);
`else
      li_got[c]  = 0;
      ivv_got[c] = 0;
`endif
      if (tog_at[c] != 0) TONE_IN = ~TONE_IN;
      enable = (en_val[c] != 0);
    end
  endtask

  // which: 0 DETECTED, 1 TONE_LOST, 2 last_interval, 3 interval_valid
  task automatic cmp_wave(input string nm, input int idx, input int which, input int L);
    int nbad = 0, first = -1, g = 0, x = 0, fg = 0, fx = 0;
    for (int c = 0; c < L; c++) begin
      case (which)
        0: begin g = det_got[c];  x = det_exp[c];  end
        1: begin g = lost_got[c]; x = lost_exp[c]; end
        2: begin g = li_got[c];   x = li_exp[c];   end
        default: begin g = ivv_got[c]; x = ivv_exp[c]; end
      endcase
      if (g != x) begin
        if (first < 0) begin first = c; fg = g; fx = x; end
        nbad++;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL %s_%0d wave%0d: %0d cycles differ, first at cycle %0d got %0d expected %0d",
               nm, idx, which, nbad, first, fg, fx);
    end
  endtask

  task automatic cmp_all(input string nm, input int idx, input int L);
    cmp_wave(nm, idx, 0, L);
    cmp_wave(nm, idx, 1, L);
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
    cmp_wave(nm, idx, 2, L);
    cmp_wave(nm, idx, 3, L);
`endif
  endtask

  initial begin
    int tl, L, n, p;

    tbl[0] = mk(4, 1, 0, 100, 100, 100, 100);
    tbl[1] = mk(4, 1, 0, 95, 105, 95, 105);
    tbl[2] = mk(4, 0, 0, 94, 100, 100, 100);
    tbl[3] = mk(4, 0, 0, 100, 100, 100, 106);
    tbl[4] = mk(7, 1, 0, 100, 100, 106, 100, 100, 100, 100);
    tbl[5] = mk(5, 0, 1, 100, 100, 100, 100, 50);
    tbl[6] = mk(5, 0, 0, 100, 100, 100, 100, 200);
    tbl[7] = mk(4, 1, 0, 103, 103, 103, 103);

    do_reset();
    check("reset_det", 0, int'(DETECTED), 0);
    check("reset_lost", 0, int'(TONE_LOST), 0);

    for (int k = 0; k < 8; k++) begin
      do_reset();
      ivq.delete();
      for (int j = 0; j < tbl[k].n; j++) ivq.push_back(int'(tbl[k].iv[j]));
      tl = build_sched();
      L  = tl + 3 + HI + 20;
      model(L);
      drive(L);
      cmp_all("vec", k, L);
      check("vec_det_end", k, det_got[tl + 3], int'(tbl[k].det_end));
      check("vec_lost_end", k, lost_got[tl + 3], int'(tbl[k].lost_end));
      if (k == 0) begin
        check("lock_before", k, det_got[407], 0);
        check("lock_at", k, det_got[408], 1);
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
        check("li_100", k, li_got[408], 100);
        check("ivv_100", k, ivv_got[408], 1);
`endif
      end
      if (k == 6) begin
        check("timeout_det_hold", k, det_got[513], 1);
        check("timeout_det_fall", k, det_got[514], 0);
        check("timeout_lost", k, lost_got[514], 1);
        check("timeout_lost_end", k, lost_got[515], 0);
      end
`ifdef TONE_DETECTOR_PERIOD_OUT_EN
      if (k == 7) check("li_103", k, li_got[tl + 3], 103);
`endif
    end

    // Disable while locked, then re-enable with the tone still running.
    do_reset();
    ivq.delete();
    for (int j = 0; j < 9; j++) ivq.push_back(100);
    tl = build_sched();
    for (int c = 420; c < 430; c++) en_val[c] = 0;
    L = tl + 3 + HI + 20;
    for (int c = 0; c < L; c++) begin
      det_exp[c]  = ((c >= 408 && c <= 420) || (c >= 908 && c < 1014)) ? 1 : 0;
      lost_exp[c] = (c == 1014) ? 1 : 0;
    end
    drive(L);
    cmp_wave("disable", 0, 0, L);
    cmp_wave("disable", 0, 1, L);
    check("disable_drop", 0, det_got[421], 0);
    check("relock", 0, det_got[908], 1);

    // Reset asserted while locked, tone still toggling.
    do_reset();
    ivq.delete();
    for (int j = 0; j < 4; j++) ivq.push_back(100);
    tl = build_sched();
    drive(412);
    check("prereset_det", 0, int'(DETECTED), 1);
    RST = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge CLK);
      #1;
      check("rst_det", j, int'(DETECTED), 0);
      check("rst_lost", j, int'(TONE_LOST), 0);
      TONE_IN = (j < 2) ? ~TONE_IN : 1'b0;
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_after_det", 0, int'(DETECTED), 0);
    check("rst_after_lost", 0, int'(TONE_LOST), 0);

    // Random interval streams, mostly near the window edges.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ivq.delete();
      n = int'($urandom_range(12, 6));
      for (int j = 0; j < n; j++) begin
        p = int'($urandom_range(99, 0));
        if (p < 70)      ivq.push_back(int'($urandom_range(HI + 1, LO - 1)));
        else if (p < 85) ivq.push_back(int'($urandom_range(90, 40)));
        else             ivq.push_back(int'($urandom_range(250, 110)));
      end
      tl = build_sched();
      L  = tl + 3 + HI + 20;
      model(L);
      drive(L);
      cmp_all("rand", r, L);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
